xgriscv_lsu: RTL

//  Load/store unit for the MEM stage. It is fed by the ALU result (address or plain result), the

---
 rtl/xgriscv_lsu.sv | 116 +++++++++++
 1 files changed

// File: rtl/xgriscv_lsu.sv
// xgriscv_lsu: MEM-stage load/store unit with req/gnt/rvalid data port, timeout and write-back record
module xgriscv_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_aluout,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_wstrb,
  input  logic            dm_gnt,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            out_valid,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic [XLEN-1:0] out_data,
  output logic            out_misalign,
  output logic            out_buserr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [7:0]      cnt;
  logic [XLEN-1:0] addr, wdat, ldata;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic            rw, accept, is_mem, misal, done, tmo;
  logic [3:0]      strb;
  logic [7:0]      lb;
  logic [15:0]     lh;
  assign in_ready = state == IDLE;
  always_comb begin
    accept  = in_valid && in_ready;
    is_mem  = in_memread || in_memwrite;
    misal   = in_funct3[1:0] == 2'b00 ? 1'b0 : in_funct3[1:0] == 2'b01 ? in_aluout[0] : |in_aluout[1:0];
    strb    = in_funct3[1:0] == 2'b00 ? 4'b0001 << in_aluout[1:0] :
              in_funct3[1:0] == 2'b01 ? 4'b0011 << in_aluout[1:0] : 4'b1111;
    wdat    = in_funct3[1:0] == 2'b00 ? {(XLEN/8){in_wdata[7:0]}} :
              in_funct3[1:0] == 2'b01 ? {(XLEN/16){in_wdata[15:0]}} : in_wdata;
    lb      = dm_rdata[{addr[1:0], 3'b000} +: 8];
    lh      = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ldata   = f3[1:0] == 2'b00 ? {{(XLEN-8){~f3[2] & lb[7]}}, lb} :
              f3[1:0] == 2'b01 ? {{(XLEN-16){~f3[2] & lh[15]}}, lh} : dm_rdata;
    // a load grant is not completion; only the response finishes a load
    done    = (state == REQ && dm_gnt && dm_we) || (state == WAIT && dm_rvalid);
    tmo     = state != IDLE && cnt == 8'(TIMEOUT - 1) && !done;
    state_n = state == IDLE ? (accept && is_mem && !misal ? REQ : IDLE) :
              (done || tmo) ? IDLE : (state == REQ && dm_gnt) ? WAIT : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      f3           <= '0;
      rd           <= '0;
      rw           <= 1'b0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_wstrb     <= '0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_data     <= '0;
      out_misalign <= 1'b0;
      out_buserr   <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= 1'b0;
      cnt       <= state == IDLE ? 8'd0 : cnt + 8'd1;
      if (accept) begin
        addr <= in_aluout;
        f3   <= in_funct3;
        rd   <= in_rd;
        rw   <= in_regwrite;
        if (!is_mem || misal) begin
          out_valid    <= 1'b1;
          out_rd       <= in_rd;
          out_regwrite <= in_regwrite && !is_mem;
          out_data     <= in_aluout;
          out_misalign <= is_mem;
          out_buserr   <= 1'b0;
        end else begin
          dm_req   <= 1'b1;
          dm_we    <= in_memwrite;
          dm_addr  <= {in_aluout[XLEN-1:2], 2'b00};
          dm_wdata <= wdat;
          dm_wstrb <= strb;
        end
      end
      if (state == REQ && (dm_gnt || tmo))
        dm_req <= 1'b0;
      if (done || tmo) begin
        out_valid    <= 1'b1;
        out_rd       <= rd;
        out_regwrite <= rw && !dm_we && !tmo;
        out_data     <= state == WAIT && dm_rvalid ? ldata : addr;
        out_misalign <= 1'b0;
        out_buserr   <= tmo;
      end
    end
  end
endmodule
